// File: rtl/decryption_seal.sv
// SEAL-style decryption m = c0 + c1*s in Z_q[x]/(x^N+1), streamed coefficient-serially in and out.
// Optional DECRYPT_DECODE_EN macro adds a registered plaintext decode (round(t*x/q) mod t) before the output fifo.

module fifo #(
    parameter int DATA_WIDTH = 5,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  n_full,
    output logic                  n_empty
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  do_wr, do_rd;

    assign n_full  = (count != (ADDR_WIDTH+1)'(DEPTH));
    assign n_empty = (count != '0);
    assign do_rd   = rd_en && n_empty;
    assign do_wr   = wr_en && n_full;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (do_rd)
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            if (do_wr && !do_rd)
                count <= count + (ADDR_WIDTH+1)'(1);
            else if (!do_wr && do_rd)
                count <= count - (ADDR_WIDTH+1)'(1);
        end
    end
endmodule

// Block negacyclic transform: loads N coefficients, then emits N transformed ones while the next block loads.
module ntt #(
    parameter int Q       = 17,
    parameter int N       = 8,
    parameter int LOGQ    = 5,
    parameter int LOGN    = 3,
    parameter int N_INV   = 15,
    parameter int PSI     = 3,
    parameter int INVERSE = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic [LOGQ-1:0] in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic [LOGQ-1:0] out_data,
    input  logic            out_ready
);
    typedef enum logic {EMIT_IDLE, EMIT_BUSY} emit_state_t;

    emit_state_t     state, state_next;
    logic [LOGQ-1:0] ld_buf [N];
    logic [LOGQ-1:0] em_buf [N];
    logic [LOGN-1:0] ld_cnt, em_cnt;
    logic            ld_full, em_last, handoff, in_fire;

    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state == EMIT_BUSY);
    assign em_last   = out_valid && out_ready && (em_cnt == LOGN'(N-1));
    assign handoff   = ld_full && ((state == EMIT_IDLE) || em_last);
    assign in_ready  = !ld_full || handoff;

    always_comb begin
        state_next = state;
        if (handoff)
            state_next = EMIT_BUSY;
        else if (em_last)
            state_next = EMIT_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= EMIT_IDLE;
            ld_cnt  <= '0;
            em_cnt  <= '0;
            ld_full <= 1'b0;
        end else begin
            state <= state_next;
            if (in_fire) begin
                ld_buf[ld_cnt] <= in_data;
                ld_cnt         <= ld_cnt + LOGN'(1);
            end
            // A full load buffer always has ld_cnt wrapped to 0, so a refill can overlap the handoff.
            if (in_fire && ld_cnt == LOGN'(N-1))
                ld_full <= 1'b1;
            else if (handoff)
                ld_full <= 1'b0;
            if (handoff) begin
                em_buf <= ld_buf;
                em_cnt <= '0;
            end else if (out_valid && out_ready) begin
                em_cnt <= em_cnt + LOGN'(1);
            end
        end
    end

    // Forward: A_k = sum a_j psi^((2k+1)j); inverse: a_j = N^-1 sum A_k psi^-((2k+1)j).
    always_comb begin
        int acc, e, p;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            if (INVERSE != 0)
                e = (2*N - ((2*i + 1) * int'(em_cnt)) % (2*N)) % (2*N);
            else
                e = ((2 * int'(em_cnt) + 1) * i) % (2*N);
            p = 1;
            for (int b = 0; b < 2*N; b++)
                if (b < e) p = (p * PSI) % Q;
            acc = (acc + int'(em_buf[i]) * p) % Q;
        end
        if (INVERSE != 0)
            acc = (acc * N_INV) % Q;
        out_data = LOGQ'(acc);
    end
endmodule

module intt #(
    parameter int Q     = 17,
    parameter int N     = 8,
    parameter int LOGQ  = 5,
    parameter int LOGN  = 3,
    parameter int N_INV = 15,
    parameter int PSI   = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic [LOGQ-1:0] in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic [LOGQ-1:0] out_data,
    input  logic            out_ready
);
    ntt #(.Q(Q), .N(N), .LOGQ(LOGQ), .LOGN(LOGN), .N_INV(N_INV), .PSI(PSI), .INVERSE(1)) u_core (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );
endmodule

module elementwise_multiplier #(
    parameter int Q    = 17,
    parameter int LOGQ = 5
) (
    input  logic            in0_valid,
    input  logic [LOGQ-1:0] in0,
    input  logic            in1_valid,
    input  logic [LOGQ-1:0] in1,
    output logic            in_ready,
    output logic            out_valid,
    output logic [LOGQ-1:0] out_data,
    input  logic            out_ready
);
    assign out_valid = in0_valid && in1_valid;
    assign in_ready  = out_ready;
    assign out_data  = LOGQ'((int'(in0) * int'(in1)) % Q);
endmodule

module polynomial_adder #(
    parameter int Q    = 17,
    parameter int LOGQ = 5
) (
    input  logic            in0_valid,
    input  logic [LOGQ-1:0] in0,
    input  logic            in1_valid,
    input  logic [LOGQ-1:0] in1,
    output logic            in_ready,
    output logic            out_valid,
    output logic [LOGQ-1:0] out_data,
    input  logic            out_ready
);
    assign out_valid = in0_valid && in1_valid;
    assign in_ready  = out_ready;
    assign out_data  = LOGQ'((int'(in0) + int'(in1)) % Q);
endmodule

module decryption_seal #(
    parameter int Q     = 17,
    parameter int N     = 8,
    parameter int LOGQ  = 5,
    parameter int LOGN  = 3,
    parameter int N_INV = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [LOGQ-1:0] cipher0_in,
    input  logic [LOGQ-1:0] cipher1_in,
    input  logic [LOGQ-1:0] secret_key_in,
    output logic            in_ready,
    output logic            out_valid,
    output logic [LOGQ-1:0] plain_out,
    output logic            out_last,
    input  logic            out_ready
);
    // Primitive 2N-th root of unity mod q, required for the negacyclic transform.
    localparam int PSI = 3;

    logic            reset_n, ntt_in_valid;
    logic            c0_ntt_ready, c1_ntt_ready, s_ntt_ready;
    logic            c0_ntt_valid, c1_ntt_valid, s_ntt_valid;
    logic [LOGQ-1:0] c0_ntt_data, c1_ntt_data, s_ntt_data;
    logic            c0_fifo_n_full, c1_fifo_n_full, s_fifo_n_full;
    logic            c0_fifo_n_empty, c1_fifo_n_empty, s_fifo_n_empty;
    logic [LOGQ-1:0] c0_fifo_data, c1_fifo_data, s_fifo_data;
    logic            mul_in_ready, mul_valid, mul_out_ready, add_in_ready, add_valid;
    logic [LOGQ-1:0] mul_data, add_data;
    logic            intt_in_ready, intt_valid, intt_out_ready;
    logic [LOGQ-1:0] intt_data;
    logic            out_fifo_wr, out_fifo_n_full, out_fifo_n_empty;
    logic [LOGQ-1:0] out_fifo_wdata, out_fifo_data;
    logic [LOGN-1:0] out_cnt;

    assign reset_n      = ~reset;
    assign in_ready     = !reset && c0_ntt_ready && c1_ntt_ready && s_ntt_ready;
    assign ntt_in_valid = in_valid && in_ready;

    ntt #(.Q(Q), .N(N), .LOGQ(LOGQ), .LOGN(LOGN), .N_INV(N_INV), .PSI(PSI)) c0_ntt (
        .clk(clk), .reset_n(reset_n), .in_valid(ntt_in_valid), .in_data(cipher0_in), .in_ready(c0_ntt_ready),
        .out_valid(c0_ntt_valid), .out_data(c0_ntt_data), .out_ready(c0_fifo_n_full));
    ntt #(.Q(Q), .N(N), .LOGQ(LOGQ), .LOGN(LOGN), .N_INV(N_INV), .PSI(PSI)) c1_ntt (
        .clk(clk), .reset_n(reset_n), .in_valid(ntt_in_valid), .in_data(cipher1_in), .in_ready(c1_ntt_ready),
        .out_valid(c1_ntt_valid), .out_data(c1_ntt_data), .out_ready(c1_fifo_n_full));
    ntt #(.Q(Q), .N(N), .LOGQ(LOGQ), .LOGN(LOGN), .N_INV(N_INV), .PSI(PSI)) s_ntt (
        .clk(clk), .reset_n(reset_n), .in_valid(ntt_in_valid), .in_data(secret_key_in), .in_ready(s_ntt_ready),
        .out_valid(s_ntt_valid), .out_data(s_ntt_data), .out_ready(s_fifo_n_full));

    fifo #(.DATA_WIDTH(LOGQ), .ADDR_WIDTH(LOGN)) c0_fifo (
        .clk(clk), .reset_n(reset_n), .wr_en(c0_ntt_valid), .wr_data(c0_ntt_data),
        .rd_en(mul_valid && c0_fifo_n_empty && add_in_ready), .rd_data(c0_fifo_data),
        .n_full(c0_fifo_n_full), .n_empty(c0_fifo_n_empty));
    fifo #(.DATA_WIDTH(LOGQ), .ADDR_WIDTH(LOGN)) c1_fifo (
        .clk(clk), .reset_n(reset_n), .wr_en(c1_ntt_valid), .wr_data(c1_ntt_data),
        .rd_en(c1_fifo_n_empty && s_fifo_n_empty && mul_in_ready), .rd_data(c1_fifo_data),
        .n_full(c1_fifo_n_full), .n_empty(c1_fifo_n_empty));
    fifo #(.DATA_WIDTH(LOGQ), .ADDR_WIDTH(LOGN)) s_fifo (
        .clk(clk), .reset_n(reset_n), .wr_en(s_ntt_valid), .wr_data(s_ntt_data),
        .rd_en(c1_fifo_n_empty && s_fifo_n_empty && mul_in_ready), .rd_data(s_fifo_data),
        .n_full(s_fifo_n_full), .n_empty(s_fifo_n_empty));

    // The product is only consumed together with its c0 partner so all three fifos pop in lockstep.
    assign mul_out_ready = add_in_ready && c0_fifo_n_empty;

    elementwise_multiplier #(.Q(Q), .LOGQ(LOGQ)) u_mul (
        .in0_valid(c1_fifo_n_empty), .in0(c1_fifo_data), .in1_valid(s_fifo_n_empty), .in1(s_fifo_data),
        .in_ready(mul_in_ready), .out_valid(mul_valid), .out_data(mul_data), .out_ready(mul_out_ready));
    polynomial_adder #(.Q(Q), .LOGQ(LOGQ)) u_add (
        .in0_valid(mul_valid), .in0(mul_data), .in1_valid(c0_fifo_n_empty), .in1(c0_fifo_data),
        .in_ready(add_in_ready), .out_valid(add_valid), .out_data(add_data), .out_ready(intt_in_ready));
    intt #(.Q(Q), .N(N), .LOGQ(LOGQ), .LOGN(LOGN), .N_INV(N_INV), .PSI(PSI)) u_intt (
        .clk(clk), .reset_n(reset_n), .in_valid(add_valid), .in_data(add_data), .in_ready(intt_in_ready),
        .out_valid(intt_valid), .out_data(intt_data), .out_ready(intt_out_ready));

`ifdef DECRYPT_DECODE_EN
    localparam int T = 2;

    logic            dec_valid;
    logic [LOGQ-1:0] dec_data;

    assign intt_out_ready = !dec_valid || out_fifo_n_full;
    assign out_fifo_wr    = dec_valid;
    assign out_fifo_wdata = dec_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_valid <= 1'b0;
            dec_data  <= '0;
        end else if (intt_out_ready) begin
            dec_valid <= intt_valid;
            dec_data  <= LOGQ'(((T * int'(intt_data) + Q / 2) / Q) % T);
        end
    end
`else
    assign intt_out_ready = out_fifo_n_full;
    assign out_fifo_wr    = intt_valid;
    assign out_fifo_wdata = intt_data;
`endif

    fifo #(.DATA_WIDTH(LOGQ), .ADDR_WIDTH(LOGN)) out_fifo (
        .clk(clk), .reset_n(reset_n), .wr_en(out_fifo_wr), .wr_data(out_fifo_wdata),
        .rd_en(out_ready), .rd_data(out_fifo_data),
        .n_full(out_fifo_n_full), .n_empty(out_fifo_n_empty));

    assign out_valid = out_fifo_n_empty;
    assign plain_out = out_fifo_n_empty ? out_fifo_data : '0;
    assign out_last  = out_valid && (out_cnt == LOGN'(N-1));

    always_ff @(posedge clk) begin
        if (reset)
            out_cnt <= '0;
        else if (out_valid && out_ready)
            out_cnt <= out_cnt + LOGN'(1);
    end
endmodule
